multicycle_fetch_unit: RTL

Instruction fetch stage of the multicycle RISC core. Holds the PC, issues one read at a time to a synchronous instruction memory, and presents the fetched instruction and its PC to decode over a valid/ready handshake. Accepts PC redirects from execute for branches and jumps. Exports PC debug taps for the top-level debug ports.

---
 rtl/multicycle_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multicycle_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one synchronous imem read at a
// time and hands the fetched word to decode over a valid/ready handshake.
module multicycle_fetch_unit #(
  parameter int unsigned             PC_WIDTH    = 8,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = {PC_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic                   imem_rd_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   fet_valid,
  input  logic                   fet_ready,
  output logic [INSTR_WIDTH-1:0] fet_instruction,
  output logic [PC_WIDTH-1:0]    fet_pc,
  output logic [PC_WIDTH-1:0]    debug_pc_out,
  output logic [PC_WIDTH-1:0]    debug_pc_input,
  output logic [15:0]            debug_fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  function automatic logic [PC_WIDTH-1:0] pc_incr(input logic [PC_WIDTH-1:0] pc);
    pc_incr = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e                 state_q, state_d, state_nrm;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_nrm;
  logic                   fet_valid_q, fet_valid_d, fet_valid_nrm;
  logic [INSTR_WIDTH-1:0] fet_instr_q, fet_instr_d, fet_instr_nrm;
  logic [PC_WIDTH-1:0]    fet_pc_q, fet_pc_d, fet_pc_nrm;
  logic                   rd_en_q, rd_en_d;
  logic [15:0]            count_q, count_d;
  logic                   handshake;

  // Next-state and datapath: normal FSM progress first, then redirect override
  always_comb begin
    state_nrm     = state_q;
    pc_nrm        = pc_q;
    fet_valid_nrm = fet_valid_q;
    fet_instr_nrm = fet_instr_q;
    fet_pc_nrm    = fet_pc_q;
    handshake     = fet_valid_q & fet_ready;

    if (handshake) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          state_nrm = S_REQ;
        end else begin
          state_nrm = S_IDLE;
        end
      end
      S_REQ: begin
        state_nrm = S_WAIT;
      end
      S_WAIT: begin
        fet_instr_nrm = imem_rdata;
        fet_pc_nrm    = pc_q;
        fet_valid_nrm = 1'b1;
        state_nrm     = S_HOLD;
      end
      S_HOLD: begin
        if (handshake) begin
          pc_nrm        = pc_incr(pc_q);
          fet_valid_nrm = 1'b0;
          if (fetch_en) begin
            state_nrm = S_REQ;
          end else begin
            state_nrm = S_IDLE;
          end
        end else begin
          state_nrm = S_HOLD;
        end
      end
      default: begin
        state_nrm     = S_IDLE;
        fet_valid_nrm = 1'b0;
      end
    endcase

    // A redirect drops any in-flight read and any unaccepted instruction;
    // a handshake in the same cycle has already been counted above.
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      fet_valid_d = 1'b0;
      fet_instr_d = fet_instr_q;
      fet_pc_d    = fet_pc_q;
      if (fetch_en) begin
        state_d = S_REQ;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      pc_d        = pc_nrm;
      fet_valid_d = fet_valid_nrm;
      fet_instr_d = fet_instr_nrm;
      fet_pc_d    = fet_pc_nrm;
      state_d     = state_nrm;
    end

    rd_en_d = (state_d == S_REQ);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fet_valid_q <= 1'b0;
      fet_instr_q <= {INSTR_WIDTH{1'b0}};
      fet_pc_q    <= {PC_WIDTH{1'b0}};
      rd_en_q     <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fet_valid_q <= fet_valid_d;
      fet_instr_q <= fet_instr_d;
      fet_pc_q    <= fet_pc_d;
      rd_en_q     <= rd_en_d;
      count_q     <= count_d;
    end
  end

  assign imem_rd_en        = rd_en_q;
  assign imem_addr         = pc_q;
  assign fet_valid         = fet_valid_q;
  assign fet_instruction   = fet_instr_q;
  assign fet_pc            = fet_pc_q;
  assign debug_pc_out      = pc_q;
  assign debug_pc_input    = rst ? RESET_PC : pc_d;
  assign debug_fetch_count = count_q;

endmodule
